pll_rst_ctrl: RTL and testbench
===============================

// Module: pll_rst_ctrl
// PURPOSE
//  Consumer side of the clock generator: drives the PLL reset input, watches the PLL lock output,
//  and produces the system reset. Holds sys_rst until lock has been stable for a fixed time.
//  Restarts the PLL on lock timeout or lock loss, and reports lock-loss events to software.
//  Runs on the free-running board reference clock (50 MHz), never on a PLL output.
// PARAMETERS
//  RST_CYCLES     16     cycles pll_rst is held high per PLL restart (>=1)
//  LOCK_TIMEOUT   50000  cycles to wait for lock before restarting PLL (1 ms @ 50 MHz, >=1)
//  STABLE_CYCLES  1024   consecutive locked cycles required before releasing sys_rst (>=1)
//  CNT_W          16     shared cycle-counter width; all three counts above must be <= 2^CNT_W-1
// PORTS
//  clk         in   1  board reference clock, free-running
//  rst         in   1  synchronous, active-high reset (already synchronised to clk)
//  pll_locked  in   1  PLL lock output, asynchronous to clk
//  sw_rst_req  in   1  1-cycle pulse: force full PLL restart
//  clr_lost    in   1  1-cycle pulse: clear lock_lost
//  pll_rst     out  1  to PLL rst input, active-high
//  sys_rst     out  1  system reset, active-high
//  lock_lost   out  1  sticky: lock dropped while in RUN
//  retry_cnt   out  8  saturating count of lock timeouts and lock losses
//  running     out  1  high in RUN state only
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high; all outputs are registered.
//  - Reset values: state=PLL_RST, counter=0, pll_rst=1, sys_rst=1, lock_lost=0, retry_cnt=0, running=0.
//  - pll_locked passes through a 2-flop synchroniser (locked_s), so there is 2 cycles of latency.
//  - PLL_RST: pll_rst=1. Stay exactly RST_CYCLES cycles, then go to WAIT_LOCK and clear the counter.
//  - WAIT_LOCK: pll_rst=0.
//    - If locked_s=1, go to STABLE and clear the counter.
//    - Else, after LOCK_TIMEOUT cycles, go to PLL_RST and increment retry_cnt.
//  - STABLE: count consecutive cycles with locked_s=1.
//    - If locked_s=0, go to WAIT_LOCK and clear the counter. Do not increment retry_cnt.
//    - At STABLE_CYCLES, go to RUN. sys_rst=0 and running=1 from the first RUN cycle.
//  - RUN: sys_rst=0.
//    - If locked_s=0, go to PLL_RST. sys_rst=1 and running=0 on the next cycle.
//    - Same transition sets lock_lost=1 and increments retry_cnt.
//  - sw_rst_req=1 in any state: next state is PLL_RST, counter=0, sys_rst=1.
//    - Does not set lock_lost and does not change retry_cnt.
//    - If it coincides with a lock-loss event in RUN, the lock-loss side effects still apply.
//  - sys_rst is 1 in every state except RUN. pll_rst is 1 only in PLL_RST.
//  - retry_cnt saturates at 255 and does not wrap.
//  - clr_lost clears lock_lost. If clr_lost coincides with a lock-loss event, set wins (lock_lost=1).
//  - rst asserted mid-operation: on the next edge all state returns to reset values, regardless of other inputs.
//  - Counter compares use ==(N-1) on a counter cleared at state entry, so dwell time is exactly N cycles.
// STRUCTURE
//  - State encodings go in the shared platform defs include: PLL_RST=2'd0, WAIT_LOCK=2'd1,
//    STABLE=2'd2, RUN=2'd3. Default parameter values also go there.
//  - One sub-module: sync_ff2 (2-flop synchroniser, 1 bit), reusable for other async inputs.
//  - A single shared CNT_W counter serves all states; the FSM and output registers sit in this module.
// TESTING (bench params: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8)
//  1. Reset then pll_locked=1 from cycle 6 -> pll_rst high exactly 4 cycles; sys_rst falls
//     8 cycles after locked_s rises; running=1; retry_cnt=0.
//  2. pll_locked held 0 -> pll_rst re-pulses every 4+20 cycles; retry_cnt counts 1,2,3...;
//     force past 255 -> stays 255.
//  3. In RUN, drop pll_locked for 1 cycle -> sys_rst=1 within 3 cycles of the drop;
//     lock_lost=1; retry_cnt+1; full restart sequence follows.
//  4. Glitch lock low for 1 cycle during STABLE at count 5 -> back to WAIT_LOCK;
//     STABLE restarts from 0; retry_cnt unchanged.
//  5. sw_rst_req in RUN -> pll_rst=1 next cycle for 4 cycles; lock_lost stays 0;
//     clr_lost on the same cycle as a lock loss -> lock_lost=1.
//  6. rst asserted mid-STABLE and mid-RUN -> all outputs equal reset values on the next edge.

Source files
------------

// File: rtl/pll_rst_ctrl_pkg.sv
// Shared definitions for the PLL reset controller: FSM encodings and default timing parameters.
package pll_rst_ctrl_pkg;

  localparam int unsigned RST_CYCLES_DEF    = 16;
  localparam int unsigned LOCK_TIMEOUT_DEF  = 50000;
  localparam int unsigned STABLE_CYCLES_DEF = 1024;
  localparam int unsigned CNT_W_DEF         = 16;
  localparam int unsigned RETRY_W           = 8;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_state_e;

endpackage

// File: rtl/sync_ff2.sv
// Two-flop synchroniser for a single asynchronous bit; synchronous active-high reset.
module sync_ff2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_rst_ctrl.sv
// PLL reset sequencer: restarts the PLL, waits for a stable lock, then releases the system reset.
module pll_rst_ctrl
  import pll_rst_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = RST_CYCLES_DEF,
  parameter int unsigned LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               sw_rst_req,
  input  logic               clr_lost,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic               running
);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = {RETRY_W{1'b1}};

  pll_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_d;
  logic               lock_lost_d;
  logic               locked_s;
  logic               timeout_evt;
  logic               lost_evt;

  sync_ff2 u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  // Next-state, shared counter and event decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    timeout_evt = 1'b0;
    lost_evt    = 1'b0;
    case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d     = PLL_RST;
          cnt_d       = '0;
          timeout_evt = 1'b1;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!locked_s) begin
          state_d  = PLL_RST;
          lost_evt = 1'b1;
        end
      end
      default: begin
        state_d = PLL_RST;
        cnt_d   = '0;
      end
    endcase

    // Software restart overrides the sequence but never masks a lock loss
    if (sw_rst_req) begin
      state_d     = PLL_RST;
      cnt_d       = '0;
      timeout_evt = 1'b0;
    end

    retry_d = retry_cnt;
    if ((timeout_evt || lost_evt) && (retry_cnt != RETRY_MAX)) begin
      retry_d = retry_cnt + RETRY_W'(1);
    end

    lock_lost_d = lock_lost;
    if (clr_lost) begin
      lock_lost_d = 1'b0;
    end
    if (lost_evt) begin
      lock_lost_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PLL_RST;
      cnt_q     <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      lock_lost <= 1'b0;
      retry_cnt <= '0;
      running   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pll_rst   <= (state_d == PLL_RST);
      sys_rst   <= (state_d != RUN);
      lock_lost <= lock_lost_d;
      retry_cnt <= retry_d;
      running   <= (state_d == RUN);
    end
  end

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Directed self-checking bench for pll_rst_ctrl with short timing parameters.
module tb_pll_rst_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       sw_rst_req;
  logic       clr_lost;
  logic       pll_rst;
  logic       sys_rst;
  logic       lock_lost;
  logic [7:0] retry_cnt;
  logic       running;

  int checks = 0;
  int errors = 0;
  int n;

  localparam int SEL_PLL = 0;
  localparam int SEL_SYS = 1;

  pll_rst_ctrl #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .CNT_W         (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .sw_rst_req (sw_rst_req),
    .clr_lost   (clr_lost),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .lock_lost  (lock_lost),
    .retry_cnt  (retry_cnt),
    .running    (running)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic cur(input int sel);
    return (sel == SEL_PLL) ? pll_rst : sys_rst;
  endfunction

  // Counts edges until the selected output reaches val; capped at max
  task automatic wait_out(input int sel, input logic val, input int max, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while ((cur(sel) !== val) && (cnt < max));
  endtask

  initial begin
    rst = 1'b1; pll_locked = 1'b0; sw_rst_req = 1'b0; clr_lost = 1'b0;
    tick(); tick();
    chk("rst_pll_rst", 32'(pll_rst), 1);
    chk("rst_sys_rst", 32'(sys_rst), 1);
    chk("rst_lock_lost", 32'(lock_lost), 0);
    chk("rst_retry", 32'(retry_cnt), 0);
    chk("rst_running", 32'(running), 0);

    // Bring-up: 4 cycles of pll_rst, then 2 sync + 1 react + 8 stable cycles
    rst = 1'b0;
    wait_out(SEL_PLL, 1'b0, 30, n);
    chk("bringup_pll_rst_len", 32'(n), 4);
    pll_locked = 1'b1;
    wait_out(SEL_SYS, 1'b0, 40, n);
    chk("bringup_sys_rst_fall", 32'(n), 11);
    chk("bringup_running", 32'(running), 1);
    chk("bringup_retry", 32'(retry_cnt), 0);
    chk("bringup_pll_rst_low", 32'(pll_rst), 0);

    // One-cycle lock drop in RUN
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    wait_out(SEL_SYS, 1'b1, 20, n);
    chk("drop_sys_rst_latency", 32'(n + 1), 3);
    chk("drop_lock_lost", 32'(lock_lost), 1);
    chk("drop_retry", 32'(retry_cnt), 1);
    chk("drop_running", 32'(running), 0);
    chk("drop_pll_rst", 32'(pll_rst), 1);
    wait_out(SEL_SYS, 1'b0, 40, n);
    chk("drop_restart_len", 32'(n), 13);

    // clr_lost, then software restart
    clr_lost = 1'b1;
    tick();
    clr_lost = 1'b0;
    chk("clr_lock_lost", 32'(lock_lost), 0);
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    chk("sw_pll_rst", 32'(pll_rst), 1);
    chk("sw_sys_rst", 32'(sys_rst), 1);
    chk("sw_running", 32'(running), 0);
    wait_out(SEL_PLL, 1'b0, 30, n);
    chk("sw_pll_rst_len", 32'(n), 4);
    chk("sw_lock_lost", 32'(lock_lost), 0);
    chk("sw_retry", 32'(retry_cnt), 1);
    wait_out(SEL_SYS, 1'b0, 40, n);
    chk("sw_sys_rst_fall", 32'(n), 9);

    // Lock loss with a coincident clr_lost: set wins
    pll_locked = 1'b0;
    tick(); tick();
    clr_lost = 1'b1;
    tick();
    clr_lost = 1'b0;
    chk("setwins_lock_lost", 32'(lock_lost), 1);
    chk("setwins_retry", 32'(retry_cnt), 2);
    chk("setwins_sys_rst", 32'(sys_rst), 1);

    // No lock: pll_rst repeats every 4+20 cycles, retry counts up and saturates
    wait_out(SEL_PLL, 1'b0, 30, n);
    chk("to1_pll_rst_len", 32'(n), 4);
    wait_out(SEL_PLL, 1'b1, 40, n);
    chk("to1_wait_len", 32'(n), 20);
    chk("to1_retry", 32'(retry_cnt), 3);
    wait_out(SEL_PLL, 1'b0, 30, n);
    chk("to2_pll_rst_len", 32'(n), 4);
    wait_out(SEL_PLL, 1'b1, 40, n);
    chk("to2_wait_len", 32'(n), 20);
    chk("to2_retry", 32'(retry_cnt), 4);
    repeat (251 * 24) tick();
    chk("sat_retry_255", 32'(retry_cnt), 255);
    chk("sat_pll_rst_phase", 32'(pll_rst), 1);
    repeat (48) tick();
    chk("sat_retry_hold", 32'(retry_cnt), 255);

    // Reset clears the saturated counter
    rst = 1'b1; pll_locked = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_retry", 32'(retry_cnt), 0);
    chk("rst2_pll_rst", 32'(pll_rst), 1);
    chk("rst2_sys_rst", 32'(sys_rst), 1);

    // Glitch seen by the FSM at STABLE count 5: RUN delayed from edge 13 to edge 20
    repeat (8) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    wait_out(SEL_SYS, 1'b0, 40, n);
    chk("glitch_sys_rst_fall", 32'(n), 11);
    chk("glitch_retry", 32'(retry_cnt), 0);
    chk("glitch_lock_lost", 32'(lock_lost), 0);
    chk("glitch_running", 32'(running), 1);

    // rst mid-RUN overrides a coincident lock loss, sw request and clear
    rst = 1'b1; sw_rst_req = 1'b1; clr_lost = 1'b1; pll_locked = 1'b0;
    tick();
    rst = 1'b0; sw_rst_req = 1'b0; clr_lost = 1'b0; pll_locked = 1'b1;
    chk("rstrun_pll_rst", 32'(pll_rst), 1);
    chk("rstrun_sys_rst", 32'(sys_rst), 1);
    chk("rstrun_running", 32'(running), 0);
    chk("rstrun_lock_lost", 32'(lock_lost), 0);
    chk("rstrun_retry", 32'(retry_cnt), 0);

    // rst mid-STABLE, then a clean full sequence
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rststable_sys_rst", 32'(sys_rst), 1);
    chk("rststable_pll_rst", 32'(pll_rst), 1);
    chk("rststable_running", 32'(running), 0);
    wait_out(SEL_SYS, 1'b0, 40, n);
    chk("rststable_restart_len", 32'(n), 13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
